// File: rtl/instruction_fetch.sv
// Program counter and fetch stage in front of a combinational instruction ROM.
// Optional macro FETCH_EARLY_JMP_EN resolves JMP at fetch and drops it from the stream.
module instruction_fetch #(
    parameter int              ADDR_W      = 16,
    parameter int              INST_W      = 30,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int              BOOT_CYCLES = 4,
    parameter logic [5:0]      JMP_OP      = 6'h0C
) (
    input  logic              Clock,
    input  logic              Reset,
    output logic [ADDR_W-1:0] oRomAddress,
    input  logic [INST_W-1:0] iRomInstruction,
    input  logic              iRedirect,
    input  logic [ADDR_W-1:0] iRedirectTarget,
    output logic [INST_W-1:0] oInstruction,
    output logic [ADDR_W-1:0] oInstPC,
    output logic              oValid,
    input  logic              iReady
);

    localparam int CNT_W = (BOOT_CYCLES == 0) ? 1 : $clog2(BOOT_CYCLES + 1);
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  boot_cnt;
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst_p1;
    logic [ADDR_W-1:0] ipc_p1;
    logic              vld_p1;
    logic              slot_open;

    // Wraps modulo 2^ADDR_W by construction of the result width.
    function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] cur);
        return cur + 1'b1;
    endfunction

`ifdef FETCH_EARLY_JMP_EN
    function automatic logic is_jmp(input logic [INST_W-1:0] inst);
        return inst[INST_W-1 -: 6] == JMP_OP;
    endfunction

    function automatic logic [ADDR_W-1:0] jmp_target(input logic [INST_W-1:0] inst);
        return ADDR_W'(inst[23:16]);
    endfunction
`endif

    // A held instruction is only replaced once decode takes it.
    assign slot_open = !vld_p1 || iReady;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= BOOT;
            boot_cnt <= '0;
            pc       <= RESET_PC;
            inst_p1  <= '0;
            ipc_p1   <= '0;
            vld_p1   <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    if (boot_cnt == BOOT_LAST) begin
                        state <= RUN;
                    end else begin
                        boot_cnt <= boot_cnt + 1'b1;
                    end
                    if (iRedirect) begin
                        pc <= iRedirectTarget;
                    end
                end
                RUN: begin
                    // fetch -> p1: redirect squashes, else capture when the slot is open
                    if (iRedirect) begin
                        pc     <= iRedirectTarget;
                        vld_p1 <= 1'b0;
                    end else if (slot_open) begin
`ifdef FETCH_EARLY_JMP_EN
                        if (is_jmp(iRomInstruction)) begin
                            pc     <= jmp_target(iRomInstruction);
                            vld_p1 <= 1'b0;
                        end else begin
                            inst_p1 <= iRomInstruction;
                            ipc_p1  <= pc;
                            vld_p1  <= 1'b1;
                            pc      <= pc_next(pc);
                        end
`else
                        inst_p1 <= iRomInstruction;
                        ipc_p1  <= pc;
                        vld_p1  <= 1'b1;
                        pc      <= pc_next(pc);
`endif
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

    assign oRomAddress  = pc;
    assign oInstruction = inst_p1;
    assign oInstPC      = ipc_p1;
    assign oValid       = vld_p1;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: per-cycle vector table with a data scoreboard,
// plus hand sequences for boot-time redirect and asynchronous reset.
module tb_instruction_fetch;

    localparam logic [5:0] TB_JMP = 6'h0C;

    logic        clk;
    logic        rst_n;
    logic [15:0] rom_addr;
    logic [29:0] rom_inst;
    logic        redir;
    logic [15:0] tgt;
    logic [29:0] o_inst;
    logic [15:0] o_ipc;
    logic        o_valid;
    logic        ready;

    int n_chk  = 0;
    int n_fail = 0;

    instruction_fetch #(
        .ADDR_W(16), .INST_W(30), .RESET_PC(16'd0), .BOOT_CYCLES(4), .JMP_OP(TB_JMP)
    ) dut (
        .Clock(clk), .Reset(rst_n), .oRomAddress(rom_addr), .iRomInstruction(rom_inst),
        .iRedirect(redir), .iRedirectTarget(tgt), .oInstruction(o_inst), .oInstPC(o_ipc),
        .oValid(o_valid), .iReady(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM image: address 17 holds JMP 7; every 8th word from 5 carries an unusual opcode.
    function automatic logic [29:0] rom_word(input logic [15:0] a);
        if (a == 16'd17) return {TB_JMP, 8'd7, 16'h0000};
        return {(a[2:0] == 3'd5) ? 6'h3F : 6'h01, a[7:0] ^ 8'hA5, a[15:8], a[7:0]};
    endfunction

    always_comb rom_inst = rom_word(rom_addr);

    typedef struct {
        logic        redir;
        logic [15:0] tgt;
        logic        ready;
        logic        exp_valid;
        logic [15:0] exp_ipc;
        logic [15:0] exp_addr;
    } vec_t;

    vec_t        vecs[$];
    logic [45:0] sb[$];

    task automatic add(input logic r, input logic [15:0] t, input logic rd,
                       input logic ev, input logic [15:0] ipc, input logic [15:0] addr);
        vec_t v;
        v.redir = r; v.tgt = t; v.ready = rd;
        v.exp_valid = ev; v.exp_ipc = ipc; v.exp_addr = addr;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; redir = 1'b0; tgt = '0; ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [45:0] e;
        int          edges;
        logic        seen;

        // Boot (edges 1-5), then fetch 0..5 back to back.
        for (int i = 0; i < 5; i++) add(0, 0, 1, 0, 0, 0);
        for (int p = 0; p <= 5; p++) add(0, 0, 1, 1, 16'(p), 16'(p + 1));
        for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 16'd5, 16'd6);
        for (int p = 6; p <= 12; p++) add(0, 0, 1, 1, 16'(p), 16'(p + 1));
        add(1, 16'd7, 1, 0, 0, 16'd7);
        add(0, 0, 1, 1, 16'd7, 16'd8);
        add(0, 0, 1, 1, 16'd8, 16'd9);
        add(1, 16'hFFFE, 1, 0, 0, 16'hFFFE);
        add(0, 0, 1, 1, 16'hFFFE, 16'hFFFF);
        add(0, 0, 1, 1, 16'hFFFF, 16'h0000);
        add(0, 0, 1, 1, 16'h0000, 16'h0001);
        add(0, 0, 0, 1, 16'h0000, 16'h0001);
        add(1, 16'd16, 0, 0, 0, 16'd16);
        add(0, 0, 0, 1, 16'd16, 16'd17);
`ifdef FETCH_EARLY_JMP_EN
        add(0, 0, 1, 0, 0, 16'd7);
        add(0, 0, 1, 1, 16'd7, 16'd8);
`else
        add(0, 0, 1, 1, 16'd17, 16'd18);
        add(0, 0, 1, 1, 16'd18, 16'd19);
`endif

        rst_n = 1'b0; redir = 1'b0; tgt = '0; ready = 1'b1;
        #2;
        chk("reset_addr", 32'(rom_addr), 32'd0);
        chk("reset_valid", 32'(o_valid), 32'd0);
        chk("reset_inst", 32'(o_inst), 32'd0);
        chk("reset_ipc", 32'(o_ipc), 32'd0);
        do_reset();

        for (int i = 0; i < vecs.size(); i++) begin
            redir = vecs[i].redir;
            tgt   = vecs[i].tgt;
            ready = vecs[i].ready;
            if (vecs[i].exp_valid) sb.push_back({vecs[i].exp_ipc, rom_word(vecs[i].exp_ipc)});
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_valid", i), 32'(o_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("row%0d_addr", i), 32'(rom_addr), 32'(vecs[i].exp_addr));
            if (o_valid) begin
                if (sb.size() == 0) begin
                    chk($sformatf("row%0d_sb_empty", i), 32'd0, 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("row%0d_ipc", i), 32'(o_ipc), 32'(e[45:30]));
                    chk($sformatf("row%0d_inst", i), 32'(o_inst), 32'(e[29:0]));
                end
            end
            @(negedge clk);
        end
        redir = 1'b0;
        chk("sb_drained", 32'(sb.size()), 32'd0);

        // Asynchronous reset while a stalled instruction is held.
        ready = 1'b0;
        @(posedge clk);
        #1;
        chk("stall_valid", 32'(o_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(o_valid), 32'd0);
        chk("async_addr", 32'(rom_addr), 32'd0);
        chk("async_ipc", 32'(o_ipc), 32'd0);
        chk("async_inst", 32'(o_inst), 32'd0);

        // Redirect during boot moves the PC but keeps the boot length.
        do_reset();
        @(posedge clk);
        @(negedge clk);
        redir = 1'b1; tgt = 16'd40;
        @(posedge clk);
        #1;
        chk("boot_redir_addr", 32'(rom_addr), 32'd40);
        chk("boot_redir_valid", 32'(o_valid), 32'd0);
        @(negedge clk);
        redir = 1'b0;
        edges = 2;
        seen  = 1'b0;
        while (!seen && edges < 20) begin
            @(posedge clk);
            edges++;
            #1;
            if (o_valid) seen = 1'b1;
        end
        chk("boot_first_edge", 32'(edges), 32'd6);
        chk("boot_first_ipc", 32'(o_ipc), 32'd40);
        chk("boot_first_inst", 32'(o_inst), 32'(rom_word(16'd40)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
